// File: rtl/sv_sum_acc_pipe.sv
// Two-stage multi-operand adder with optional running accumulation and valid/ready flow control.
// Define SV_SUM_ACC_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module sv_sum_acc_pipe #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4,
  parameter int ACC_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic                    in_mode,
  input  logic                    acc_clr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        out_data,
  output logic                    out_ovf
);

  localparam int SUM_W = WIDTH + $clog2(NUM_IN);
  localparam int HALF  = NUM_IN / 2;

  logic             s1_valid_r;
  logic             s1_mode_r;
  logic [SUM_W-1:0] p0_r;
  logic [SUM_W-1:0] p1_r;
  logic [ACC_W-1:0] acc_r;
  logic             ovf_r;
  logic             out_valid_r;
  logic [ACC_W-1:0] out_data_r;
  logic             out_ovf_r;

  logic             s2_adv_s;
  logic             s2_load_s;
  logic [SUM_W-1:0] p0_s;
  logic [SUM_W-1:0] p1_s;
  logic [SUM_W-1:0] total_s;
  logic [ACC_W-1:0] acc_eff_s;
  logic             ovf_eff_s;
  logic [ACC_W:0]   nxt_s;
  logic [ACC_W-1:0] res_s;
  logic             ovf_res_s;

  assign s2_adv_s  = !out_valid_r || out_ready;
  assign s2_load_s = s2_adv_s && s1_valid_r;
  assign in_ready  = !s1_valid_r || s2_adv_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_ovf   = out_ovf_r;

  // Stage-1 half sums: lower and upper operand groups.
  always_comb begin
    p0_s = '0;
    p1_s = '0;
    for (int k = 0; k < HALF; k++) begin
      p0_s = p0_s + SUM_W'(in_data[k*WIDTH +: WIDTH]);
      p1_s = p1_s + SUM_W'(in_data[(k+HALF)*WIDTH +: WIDTH]);
    end
  end

  // Stage-2 result; a coincident acc_clr makes the load see an empty accumulator.
  always_comb begin
    total_s   = p0_r + p1_r;
    acc_eff_s = acc_clr ? '0 : acc_r;
    ovf_eff_s = acc_clr ? 1'b0 : ovf_r;
    nxt_s     = {1'b0, acc_eff_s} + (ACC_W+1)'(total_s);
    if (s1_mode_r) begin
      ovf_res_s = ovf_eff_s | nxt_s[ACC_W];
`ifdef SV_SUM_ACC_SATURATE_EN
      res_s = nxt_s[ACC_W] ? {ACC_W{1'b1}} : nxt_s[ACC_W-1:0];
`else
      res_s = nxt_s[ACC_W-1:0];
`endif
    end else begin
      ovf_res_s = ovf_eff_s;
      res_s     = ACC_W'(total_s);
    end
  end

  // Stage-1 register: captures half sums whenever the stage can move.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_mode_r  <= 1'b0;
      p0_r       <= '0;
      p1_r       <= '0;
    end else if (in_ready) begin
      s1_valid_r <= in_valid;
      s1_mode_r  <= in_mode;
      p0_r       <= p0_s;
      p1_r       <= p1_s;
    end
  end

  // Stage-2 output register, accumulator and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_ovf_r   <= 1'b0;
      acc_r       <= '0;
      ovf_r       <= 1'b0;
    end else begin
      if (s2_adv_s) begin
        out_valid_r <= s1_valid_r;
        if (s1_valid_r) begin
          out_data_r <= res_s;
          out_ovf_r  <= ovf_res_s;
        end
      end
      if (s2_load_s && s1_mode_r) begin
        acc_r <= res_s;
        ovf_r <= ovf_res_s;
      end else if (acc_clr) begin
        acc_r <= '0;
        ovf_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sv_sum_acc_pipe.sv
// Scoreboard bench for sv_sum_acc_pipe (WIDTH=8, NUM_IN=4, ACC_W=10); follows SV_SUM_ACC_SATURATE_EN.
module tb_sv_sum_acc_pipe;
  localparam int ACC_W = 10;
  localparam int LIM   = 1 << ACC_W;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'd0;
  logic        in_mode = 1'b0;
  logic        acc_clr = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [ACC_W-1:0] out_data;
  logic        out_ovf;

  sv_sum_acc_pipe #(.WIDTH(8), .NUM_IN(4), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .acc_clr(acc_clr), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct { int d; bit o; } exp_t;
  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   m_acc  = 0;
  bit   m_ovf  = 1'b0;
  int   hold_cnt = 0;
  bit   bp = 1'b0;
  int   accept_total = 0;
  int   first_stall = -1;
  bit   held = 1'b0;
  int   held_d = 0;
  bit   held_o = 1'b0;

  function automatic logic [31:0] pack(input int a, input int b, input int c, input int d);
    logic [7:0] a8, b8, c8, d8;
    a8 = a[7:0]; b8 = b[7:0]; c8 = c[7:0]; d8 = d[7:0];
    return {d8, c8, b8, a8};
  endfunction

  // Reference: plain sum, or running sum with sticky overflow (wrap or clamp).
  function automatic void push_expect(input logic [31:0] d, input logic m);
    int   total;
    int   s;
    exp_t e;
    total = 0;
    for (int k = 0; k < 4; k++) total += int'(d[8*k +: 8]);
    if (m) begin
      s = m_acc + total;
      if (s >= LIM) begin
        m_ovf = 1'b1;
`ifdef SV_SUM_ACC_SATURATE_EN
        m_acc = LIM - 1;
`else
        m_acc = s % LIM;
`endif
      end else begin
        m_acc = s;
      end
      e.d = m_acc;
    end else begin
      e.d = total;
    end
    e.o = m_ovf;
    exp_q.push_back(e);
  endfunction

  task automatic drive_ready();
    if (hold_cnt > 0) begin
      out_ready = 1'b0;
      hold_cnt--;
    end else begin
      out_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  endtask

  task automatic send(input logic [31:0] d, input logic m);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    while (!done) begin
      drive_ready();
      @(negedge clk);
      if (in_ready) begin
        push_expect(d, m);
        accept_total++;
        done = 1'b1;
      end else if (first_stall < 0) begin
        first_stall = accept_total;
      end
      @(posedge clk); #1;
      n++;
      if (!done && n > 60) begin
        errors++; checks++;
        $display("FAIL accept_timeout: in_ready stayed %0b, required 1 within 60 cycles", in_ready);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n, input bit clr);
    for (int i = 0; i < n; i++) begin
      acc_clr = clr;
      drive_ready();
      @(posedge clk); #1;
      acc_clr = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      idle(1, 1'b0);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic clear_acc();
    drain();
    idle(1, 1'b1);
    m_acc = 0;
    m_ovf = 1'b0;
  endtask

  // Monitor: pops on every output handshake and checks that stalled outputs hold.
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        checks++;
        if (!out_valid || int'(out_data) != held_d || out_ovf != held_o) begin
          errors++;
          $display("FAIL hold_stable: valid=%0b data=%0d ovf=%0b, required valid=1 data=%0d ovf=%0b",
                   out_valid, out_data, out_ovf, held_d, held_o);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: data=%0d ovf=%0b, required no output", out_data, out_ovf);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (int'(out_data) != e.d || out_ovf != e.o) begin
            errors++;
            $display("FAIL result: data=%0d ovf=%0b, required data=%0d ovf=%0b",
                     out_data, out_ovf, e.d, e.o);
          end
        end
      end
      held   = out_valid && !out_ready;
      held_d = int'(out_data);
      held_o = out_ovf;
    end
  end

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0b, required %0b", name, act, req);
    end
  endtask

  initial begin
    int base;
    #1 rst = 1'b1;
    #1;
    check_bit("reset_out_valid", out_valid, 1'b0);
    check_bit("reset_out_ovf", out_ovf, 1'b0);
    check_bit("reset_in_ready", in_ready, 1'b1);
    check_bit("reset_out_data_zero", out_data == '0, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // plain sum of maximal operands
    send(pack(255, 255, 255, 255), 1'b0);
    drain();

    // accumulation into overflow
    clear_acc();
    for (int i = 0; i < 3; i++) send(pack(100, 100, 100, 100), 1'b1);
    drain();

    // clear coinciding with an S2 load while the sticky flag is set
    m_acc = 0; m_ovf = 1'b0;
    send(pack(1, 2, 3, 4), 1'b1);
    idle(1, 1'b1);
    drain();

    // same collision from acc=500
    clear_acc();
    send(pack(125, 125, 125, 125), 1'b1);
    drain();
    m_acc = 0; m_ovf = 1'b0;
    send(pack(1, 2, 3, 4), 1'b1);
    idle(1, 1'b1);
    drain();

    // backpressure: six inputs against a five-cycle stall
    base = accept_total;
    first_stall = -1;
    hold_cnt = 5;
    for (int i = 0; i < 6; i++) send(pack(i, 10 * i, 3, 200 - i), 1'b0);
    drain();
    checks++;
    if (first_stall - base != 2) begin
      errors++;
      $display("FAIL stall_point: in_ready dropped after %0d accepts, required 2", first_stall - base);
    end

    // mixed modes: the plain sum leaves the accumulator alone
    clear_acc();
    send(pack(1, 1, 1, 1), 1'b1);
    send(pack(9, 9, 9, 9), 1'b0);
    send(pack(1, 1, 1, 1), 1'b1);
    drain();

    // reset with two transactions in flight
    hold_cnt = 20;
    send(pack(7, 7, 7, 7), 1'b1);
    send(pack(8, 8, 8, 8), 1'b1);
    rst = 1'b1;
    #1;
    check_bit("rst_flush_out_valid", out_valid, 1'b0);
    check_bit("rst_flush_in_ready", in_ready, 1'b1);
    exp_q.delete();
    m_acc = 0; m_ovf = 1'b0;
    hold_cnt = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(3, 1'b0);
    check_bit("rst_no_stale_out", out_valid, 1'b0);
    send(pack(1, 2, 3, 4), 1'b1);
    drain();

    // randomized traffic with random backpressure and occasional clears
    bp = 1'b1;
    for (int i = 0; i < 250; i++) begin
      send($urandom, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 3)), 1'b0);
      if ($urandom_range(0, 39) == 0) clear_acc();
    end
    bp = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1);
  end
endmodule
